// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the IF fetch unit: FSM states, reset PC and
// the PC increment helper used by the next-PC mux.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;

  // Sequential PC step; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-fetch bus (req/addr_ok/data_ok) between the IF stage (master)
// and the instruction memory or cache (slave).
interface if_fetch_unit_if;

  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;

  modport master (
    output inst_req_o,
    output inst_addr_o,
    input  inst_addr_ok_i,
    input  inst_data_ok_i,
    input  inst_rdata_i
  );

  modport slave (
    input  inst_req_o,
    input  inst_addr_o,
    output inst_addr_ok_i,
    output inst_data_ok_i,
    output inst_rdata_i
  );

endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, keeps one fetch in flight or buffered, hands it to ID,
// and applies branch/jump redirects after the delay slot and exception redirects.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               branch_i,
  input  logic               br_taken_i,
  input  logic [31:0]        br_target_i,
  input  logic               jump_i,
  input  logic [31:0]        jump_target_i,
  input  logic               exc_i,
  input  logic [31:0]        exc_pc_i,
  if_fetch_unit_if.master    bus,
  output logic               inst_valid_o,
  output logic [31:0]        inst_o,
  output logic [31:0]        pc_o,
  output logic               adel_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  redir_pc_q;
  logic         redir_v_q;
  logic         drop_q;
  logic [31:0]  inst_q;
  logic [31:0]  pcOut_q;
  logic         adel_q;

  logic         redirNow;
  logic [31:0]  redirTarget;
  logic         pcAligned;
  logic [31:0]  nextPc_d;

  assign redirNow    = ~stall_i & (jump_i | (branch_i & br_taken_i));
  assign redirTarget = jump_i ? jump_target_i : br_target_i;
  assign pcAligned   = (pc_q[1:0] == 2'b00);

  // A redirect decided in the same cycle the delay slot returns must still win.
  always_comb begin
    nextPc_d = pcPlus4(pc_q);
    if (redirNow) begin
      nextPc_d = redirTarget;
    end else if (redir_v_q) begin
      nextPc_d = redir_pc_q;
    end
  end

  assign bus.inst_req_o  = (state_q == S_REQ) && pcAligned;
  assign bus.inst_addr_o = pc_q;
  assign inst_valid_o    = (state_q == S_HOLD);
  assign inst_o          = inst_q;
  assign pc_o            = pcOut_q;
  assign adel_o          = adel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      redir_pc_q <= ZERO_WORD;
      redir_v_q  <= 1'b0;
      drop_q     <= 1'b0;
      inst_q     <= ZERO_WORD;
      pcOut_q    <= ZERO_WORD;
      adel_q     <= 1'b0;
    end else if (exc_i) begin
      // An accepted or outstanding fetch still owes a data_ok; mark it for discard.
      pc_q      <= exc_pc_i;
      redir_v_q <= 1'b0;
      case (state_q)
        S_REQ: begin
          if (bus.inst_req_o && bus.inst_addr_ok_i) begin
            drop_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.inst_data_ok_i) begin
            drop_q  <= 1'b0;
            state_q <= S_REQ;
          end else begin
            drop_q <= 1'b1;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (redirNow) begin
            redir_v_q  <= 1'b1;
            redir_pc_q <= redirTarget;
          end
          if (!pcAligned) begin
            inst_q  <= ZERO_WORD;
            pcOut_q <= pc_q;
            adel_q  <= 1'b1;
            state_q <= S_HOLD;
          end else if (bus.inst_addr_ok_i) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.inst_data_ok_i && !drop_q) begin
            inst_q    <= bus.inst_rdata_i;
            pcOut_q   <= pc_q;
            adel_q    <= 1'b0;
            pc_q      <= nextPc_d;
            redir_v_q <= 1'b0;
            state_q   <= S_HOLD;
          end else begin
            if (redirNow) begin
              redir_v_q  <= 1'b1;
              redir_pc_q <= redirTarget;
            end
            if (bus.inst_data_ok_i) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end
          end
        end
        S_HOLD: begin
          // The delay slot is already buffered, so the target goes straight into the PC.
          if (redirNow) begin
            pc_q <= redirTarget;
          end
          if (!stall_i) begin
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule
